// File: rtl/ids_multi_match_if.sv
// Upstream/downstream word stream of the inline payload inspection stage.
// The stage itself sits on the slave side; traffic sources use master.
interface ids_multi_match_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr
    );

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/ids_multi_match.sv
// Inline multi-pattern payload inspection stage: input FIFO, registered
// pass-through, masked per-word pattern hits, end-of-packet alert/counters.
module ids_multi_match #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_PATTERNS    = 4,
    parameter int HEADER_WORDS    = 3,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    ids_multi_match_if.slave               bus,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] cfg_pattern,
    input  logic [NUM_PATTERNS*CTRL_WIDTH-1:0] cfg_mask,
    input  logic [NUM_PATTERNS-1:0]        cfg_pat_en,
    input  logic                           cfg_clear,
    output logic                           alert_valid,
    output logic [NUM_PATTERNS-1:0]        alert_bitmap,
    output logic [NUM_PATTERNS*32-1:0]     match_count,
    output logic [31:0]                    pkt_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int PW    = FIFO_DEPTH_BITS + 1;
    localparam int HCW   = $clog2(HEADER_WORDS + 1);

    typedef enum logic [1:0] {
        S_START,
        S_HDR,
        S_PAYLOAD
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem_d [DEPTH];
    logic [CTRL_WIDTH-1:0] r_mem_c [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic                  r_in_rdy;

    logic [PW-1:0]         w_occ, w_occ_nxt;
    logic                  w_full, w_empty, w_push, w_pop;
    logic [DATA_WIDTH-1:0] w_data;
    logic [CTRL_WIDTH-1:0] w_ctrl;

    assign w_occ   = r_wptr - r_rptr;
    assign w_full  = (w_occ == PW'(DEPTH));
    assign w_empty = (w_occ == '0);
    // A write into a full FIFO is a protocol violation and is dropped.
    assign w_push  = bus.in_wr && !w_full;
    assign w_pop   = !w_empty && bus.out_rdy;
    assign w_data  = r_mem_d[r_rptr[FIFO_DEPTH_BITS-1:0]];
    assign w_ctrl  = r_mem_c[r_rptr[FIFO_DEPTH_BITS-1:0]];
    assign w_occ_nxt = w_occ + PW'(w_push) - PW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wptr[FIFO_DEPTH_BITS-1:0]] <= bus.in_data;
            r_mem_c[r_wptr[FIFO_DEPTH_BITS-1:0]] <= bus.in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_in_rdy <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_in_rdy <= (w_occ_nxt <= PW'(DEPTH - 2));
        end
    end

    assign bus.in_rdy = r_in_rdy;

    logic [NUM_PATTERNS-1:0] w_hit;

    always_comb begin
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            w_hit[i] = cfg_pat_en[i] &&
                       (cfg_mask[i*CTRL_WIDTH +: CTRL_WIDTH] != '0);
            for (int b = 0; b < CTRL_WIDTH; b++) begin
                if (cfg_mask[i*CTRL_WIDTH + b] &&
                    (w_data[8*b +: 8] !=
                     cfg_pattern[i*DATA_WIDTH + 8*b +: 8]))
                    w_hit[i] = 1'b0;
            end
        end
    end

    state_t                  r_state, w_state_nxt;
    logic [HCW-1:0]          r_hdr_cnt, w_hdr_nxt, w_hdr_inc;
    logic [NUM_PATTERNS-1:0] r_flags, w_flags_nxt, w_bitmap;
    logic                    w_eop, w_ctrl_nz;

    assign w_ctrl_nz = (w_ctrl != '0);
    assign w_hdr_inc = r_hdr_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_START;
            r_hdr_cnt <= '0;
            r_flags   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hdr_cnt <= w_hdr_nxt;
            r_flags   <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_nxt   = r_hdr_cnt;
        w_flags_nxt = r_flags;
        w_eop       = 1'b0;
        w_bitmap    = '0;
        if (w_pop) begin
            unique case (r_state)
                S_START: begin
                    if (w_ctrl_nz) begin
                        w_state_nxt = S_HDR;
                        w_hdr_nxt   = '0;
                        w_flags_nxt = '0;
                    end
                end
                S_HDR: begin
                    if (!w_ctrl_nz) begin
                        w_hdr_nxt = w_hdr_inc;
                        if (w_hdr_inc == HCW'(HEADER_WORDS))
                            w_state_nxt = S_PAYLOAD;
                    end else if (r_hdr_cnt != '0) begin
                        // Packet ended inside the header: nothing inspected.
                        w_eop       = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
                S_PAYLOAD: begin
                    w_flags_nxt = r_flags | w_hit;
                    if (w_ctrl_nz) begin
                        w_eop       = 1'b1;
                        w_bitmap    = r_flags | w_hit;
                        w_state_nxt = S_START;
                    end
                end
                default: w_state_nxt = S_START;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0]              r_out_data;
    logic [CTRL_WIDTH-1:0]              r_out_ctrl;
    logic                               r_out_wr;
    logic                               r_alert_valid;
    logic [NUM_PATTERNS-1:0]            r_alert_bitmap;
    logic [NUM_PATTERNS-1:0][31:0]      r_match_cnt;
    logic [31:0]                        r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data     <= '0;
            r_out_ctrl     <= '0;
            r_out_wr       <= 1'b0;
            r_alert_valid  <= 1'b0;
            r_alert_bitmap <= '0;
            r_match_cnt    <= '0;
            r_pkt_cnt      <= '0;
        end else begin
            r_out_wr      <= w_pop;
            r_alert_valid <= w_eop;
            if (w_pop) begin
                r_out_data <= w_data;
                r_out_ctrl <= w_ctrl;
            end
            if (w_eop) r_alert_bitmap <= w_bitmap;
            if (cfg_clear) begin
                r_match_cnt <= '0;
                r_pkt_cnt   <= '0;
            end else if (w_eop) begin
                if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 32'd1;
                for (int i = 0; i < NUM_PATTERNS; i++) begin
                    if (w_bitmap[i] && (r_match_cnt[i] != '1))
                        r_match_cnt[i] <= r_match_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ctrl  = r_out_ctrl;
    assign bus.out_wr    = r_out_wr;
    assign alert_valid   = r_alert_valid;
    assign alert_bitmap  = r_alert_bitmap;
    assign match_count   = r_match_cnt;
    assign pkt_count     = r_pkt_cnt;
endmodule

// File: doc/ids_multi_match.md
# ids_multi_match

Parametrised multi-pattern payload inspection stage for the user data path, the next generation of the single-pattern IDS. It sits inline between two 64-bit NetFPGA-style packet stages. It buffers words in a small input FIFO and forwards every word unchanged through a registered output. It compares each payload word against NUM_PATTERNS masked 64-bit patterns. At end of packet it raises a one-cycle alert carrying the per-pattern match bitmap and updates saturating per-pattern match counters and a packet counter.

## Interface
- DATA_WIDTH, 64, stream data width; must be a multiple of 8.
- CTRL_WIDTH, DATA_WIDTH/8, stream control width; one bit per byte.
- NUM_PATTERNS, 4, number of independent patterns, 1..16.
- HEADER_WORDS, 3, number of ctrl==0 words skipped before payload inspection; must be at least 1.
- FIFO_DEPTH_BITS, 2, input FIFO depth is 2^FIFO_DEPTH_BITS entries.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream word and write strobe.
- in_rdy  out  1  upstream may write next cycle.
- out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  downstream word and write strobe.
- out_rdy  in  1  downstream can accept a word.
- cfg_pattern  in  NUM_PATTERNS*DATA_WIDTH  pattern i is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- cfg_mask  in  NUM_PATTERNS*CTRL_WIDTH  byte-compare mask; mask i is in bits [i*CTRL_WIDTH +: CTRL_WIDTH].
- cfg_pat_en  in  NUM_PATTERNS  per-pattern enable.
- cfg_clear  in  1  single-cycle pulse; clears all counters.
- alert_valid  out  1  one-cycle pulse at end of packet.
- alert_bitmap  out  NUM_PATTERNS  patterns matched in the finished packet.
- match_count  out  NUM_PATTERNS*32  saturating per-pattern packet match counts.
- pkt_count  out  32  saturating count of completed packets.

## Operation
- FIFO: fall-through. Write when in_wr is high; a write while the FIFO is full is a protocol violation and is dropped. in_rdy = (occupancy <= depth-2).
- Pop: a word pops when the FIFO is not empty and out_rdy is high. Only popped words advance the FSM and comparators.
- Byte i is data[8i+7:8i]. Pattern i hits a word when cfg_pat_en[i] is high, cfg_mask i is non-zero, and every byte whose mask bit is 1 equals the pattern byte. An all-zero mask never hits.
- Matching is word-aligned only; there is no cross-word matching.
- FSM states: START, HDR, PAYLOAD.
  - START: a popped word with ctrl!=0 -> HDR, hdr_cnt=0, match flags cleared. A popped word with ctrl==0 is forwarded but not inspected; the FSM stays in START.
  - HDR: ctrl!=0 while hdr_cnt==0 is another module header; stay in HDR. A ctrl==0 word increments hdr_cnt; when hdr_cnt reaches HEADER_WORDS -> PAYLOAD. A ctrl!=0 word while hdr_cnt>0 is a short packet: end of packet with an empty bitmap -> START.
  - PAYLOAD: every popped word is compared and hits OR into the match flags. ctrl!=0 marks the last word: it is compared too, then end of packet -> START.
- End of packet:
  - alert_valid=1 and alert_bitmap = final flags, including the last word's hits.
  - match_count[i] +1 for each set bit, saturating at 0xFFFFFFFF.
  - pkt_count +1, saturating at 0xFFFFFFFF.
- cfg_clear zeroes all counters. If cfg_clear coincides with an increment, the clear wins and the result is 0. cfg_clear does not affect the FSM or in-flight flags.
- Config inputs are sampled per popped word; mid-packet changes affect only later words.
- Reset: FIFO empty, FSM START, flags 0, every output 0 (in_rdy becomes 1 the cycle after reset deasserts).

## Timing
- Popped word at cycle t appears on out_data/out_ctrl with out_wr=1 at cycle t+1; otherwise out_wr=0 and out_data/out_ctrl hold their values.
- Minimum in_wr-to-out_wr latency is 2 cycles; throughput is 1 word/cycle while out_rdy stays high.
- alert_valid and the counter updates appear in the same cycle as out_wr for the last word.
- out_rdy low stalls pops only; there is no combinational path from out_rdy to out_wr.
- Back-to-back packets: the START check applies to the word popped immediately after an end of packet, with no bubble.

## Test plan
- Pattern 0 = 0x0102030405060708, mask 0xFF, enabled; send a packet with 1 module header, 3 header words and payload word 3 = pattern -> alert_bitmap=0001, match_count[0]=1, pkt_count=1, output identical to input.
- Mask 0x0F, pattern low 4 bytes = 0xAABBCCDD; payload word 0x11223344AABBCCDD -> hit. Same word with all-zero mask -> no hit.
- Pattern present only in a header word -> bitmap 0. Pattern in the last (ctrl!=0) word -> bitmap bit set.
- Toggle out_rdy 50% during a 10-word packet with in_wr continuous -> in_rdy deasserts at occupancy 3 (depth 4), no word is lost or duplicated, and alert fires with the last word.
- Preload match_count[1] to saturation via 0xFFFFFFFF matches (force) -> stays 0xFFFFFFFF. cfg_clear on the alert cycle -> all counters 0.
- Assert reset mid-payload -> all outputs 0 next cycle; the following fresh packet is counted as pkt_count=1.
